// File: rtl/dcache_sdq_alloc.sv
// Store data queue for the non-blocking L1 D-cache: lowest-free allocation,
// indexed 1-cycle read, explicit free by index, occupancy and illegal-free flag.
//
// Optional feature macro: DCACHE_SDQ_BYPASS_EN
//   defined   : a read of the entry being allocated this cycle returns alloc_data
//   undefined : the same read returns the entry's previous contents
//
// Ports:
//   clock, reset_n (synchronous, active-low)
//   alloc_valid/alloc_ready/alloc_data/alloc_idx : allocate lowest free entry
//   rd_valid/rd_idx -> rd_data_valid/rd_data      : 1-cycle indexed read
//   free_valid/free_idx                           : release an entry
//   count/empty/full                              : registered occupancy
//   err_free                                      : 1-cycle pulse on illegal free
module dcache_sdq_alloc #(
  parameter int DEPTH     = 17,
  parameter int DATA_BITS = 64,
  parameter int IDX_BITS  = $clog2(DEPTH),
  parameter int CNT_BITS  = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [DATA_BITS-1:0] alloc_data,
  output logic [IDX_BITS-1:0]  alloc_idx,
  input  logic                 rd_valid,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic                 rd_data_valid,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 free_valid,
  input  logic [IDX_BITS-1:0]  free_idx,
  output logic [CNT_BITS-1:0]  count,
  output logic                 empty,
  output logic                 full,
  output logic                 err_free
);

  localparam logic [IDX_BITS:0]   DEPTH_I = (IDX_BITS + 1)'(DEPTH);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  count_d;
  logic                 full_q;
  logic                 empty_q;
  logic                 rdv_q;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 err_q;

  logic                 fire;
  logic                 free_ok;
  logic                 free_in;
  logic                 rd_in;
  logic [IDX_BITS-1:0]  low_free;
  logic [DATA_BITS-1:0] rd_word;

  // Allocator sees only registered state: a slot freed this cycle is
  // not offered until the next one.
  always_comb begin
    low_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) low_free = IDX_BITS'(i);
    end
  end

  assign fire    = alloc_valid & ~full_q;
  assign free_in = {1'b0, free_idx} < DEPTH_I;
  assign rd_in   = {1'b0, rd_idx} < DEPTH_I;
  assign free_ok = free_valid & free_in & valid_q[free_idx];

  always_comb begin
    valid_d = valid_q;
    if (fire)    valid_d[low_free] = 1'b1;
    if (free_ok) valid_d[free_idx] = 1'b0;
  end

  assign count_d = count_q + CNT_BITS'(fire) - CNT_BITS'(free_ok);

  always_comb begin
    rd_word = '0;
    if (rd_in) rd_word = mem_q[rd_idx];
`ifdef DCACHE_SDQ_BYPASS_EN
    if (fire && rd_idx == low_free) rd_word = alloc_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rdv_q     <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      full_q  <= count_d == DEPTH_C;
      empty_q <= count_d == '0;
      rdv_q   <= rd_valid;
      if (rd_valid) rd_data_q <= rd_word;
      err_q   <= free_valid & ~free_ok;
    end
  end

  // Storage has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && fire) mem_q[low_free] <= alloc_data;
  end

  assign alloc_ready   = ~full_q;
  assign alloc_idx     = low_free;
  assign rd_data_valid = rdv_q;
  assign rd_data       = rd_data_q;
  assign count         = count_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign err_free      = err_q;

endmodule
